// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode.
// Results carry the uncompensated CORDIC gain (~1.6468); the consumer scales.
module cordic_iter #(
    parameter int DW   = 16,
    parameter int AW   = 12,
    parameter int AF   = 4,    // 0..16
    parameter int ITER = 12    // 1..16
) (
    input  logic          c_clk,
    input  logic          c_rst,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_y,
    input  logic [AW-1:0] i_z,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW+1:0] o_x,
    output logic [DW+1:0] o_y,
    output logic [AW-1:0] o_z
);
    // state | meaning
    // IDLE  | waiting for i_start; outputs hold the last result
    // RUN   | one micro-rotation per clock, iterations 0..ITER-1

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t               state, state_nxt;
    logic                 load, step, last;
    logic                 mode_r;
    logic [3:0]           iter_r;
    logic signed [DW+1:0] x_r, y_r, x_sh, y_sh, x_nxt, y_nxt;
    logic signed [AW-1:0] z_r, z_nxt;
    logic                 d_pos;
    logic [AW-1:0]        atan_tab [16];

    // atan(2^-i) in degrees scaled by 2^16, floored; shifting right keeps the floor
    function automatic logic [AW-1:0] atan_entry(input int idx);
        logic [31:0] full;
        case (idx)
            0:       full = 32'd2949120;
            1:       full = 32'd1740967;
            2:       full = 32'd919879;
            3:       full = 32'd466945;
            4:       full = 32'd234378;
            5:       full = 32'd117303;
            6:       full = 32'd58666;
            7:       full = 32'd29334;
            8:       full = 32'd14667;
            9:       full = 32'd7333;
            10:      full = 32'd3666;
            11:      full = 32'd1833;
            12:      full = 32'd916;
            13:      full = 32'd458;
            14:      full = 32'd229;
            default: full = 32'd114;
        endcase
        return AW'(full >> (16 - AF));
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_atan
        assign atan_tab[g] = atan_entry(g);
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (iter_r == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_sh  = x_r >>> iter_r;
        y_sh  = y_r >>> iter_r;
        // rotation drives z toward 0, vectoring drives y toward 0
        d_pos = mode_r ? y_r[DW+1] : ~z_r[AW-1];
        if (d_pos) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_tab[iter_r];
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_tab[iter_r];
        end
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            mode_r <= 1'b0;
            iter_r <= '0;
            o_done <= 1'b0;
            o_x    <= '0;
            o_y    <= '0;
            o_z    <= '0;
        end else begin
            o_done <= last;
            if (load) begin
                x_r    <= {{2{i_x[DW-1]}}, i_x};
                y_r    <= {{2{i_y[DW-1]}}, i_y};
                z_r    <= i_mode ? '0 : i_z;
                mode_r <= i_mode;
                iter_r <= '0;
            end else if (step) begin
                x_r    <= x_nxt;
                y_r    <= y_nxt;
                z_r    <= z_nxt;
                iter_r <= iter_r + 4'd1;
            end
            if (last) begin
                o_x <= x_nxt;
                o_y <= y_nxt;
                o_z <= z_nxt;
            end
        end
    end

    assign o_busy = (state == RUN);

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: the driver pushes model results, monitors
// pop and compare on every o_done pulse.
module tb_cordic_iter;
    localparam int DW = 16, AW = 12, AF = 4, ITER = 12, ITER16 = 16;

    logic          c_clk = 1'b0;
    logic          c_rst;
    logic          i_start, i_mode;
    logic [DW-1:0] i_x, i_y;
    logic [AW-1:0] i_z;
    logic          o_busy, o_done;
    logic [DW+1:0] o_x, o_y;
    logic [AW-1:0] o_z;

    logic          s_start, s_mode;
    logic [DW-1:0] s_x, s_y;
    logic [AW-1:0] s_z;
    logic          s_busy, s_done;
    logic [DW+1:0] s_ox, s_oy;
    logic [AW-1:0] s_oz;

    cordic_iter #(.DW(DW), .AW(AW), .AF(AF), .ITER(ITER)) dut (
        .c_clk(c_clk), .c_rst(c_rst), .i_start(i_start), .i_mode(i_mode),
        .i_x(i_x), .i_y(i_y), .i_z(i_z), .o_busy(o_busy), .o_done(o_done),
        .o_x(o_x), .o_y(o_y), .o_z(o_z)
    );

    cordic_iter #(.DW(DW), .AW(AW), .AF(AF), .ITER(ITER16)) dut16 (
        .c_clk(c_clk), .c_rst(c_rst), .i_start(s_start), .i_mode(s_mode),
        .i_x(s_x), .i_y(s_y), .i_z(s_z), .o_busy(s_busy), .o_done(s_done),
        .o_x(s_ox), .o_y(s_oy), .o_z(s_oz)
    );

    always #5 c_clk = ~c_clk;

    longint cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    typedef struct {
        string  name;
        int     x, y, z;
        longint cyc;
        bit     approx, zchk;
        int     ax, ay, az, txy, tz;
    } exp_t;

    exp_t q[$];
    exp_t q16[$];
    exp_t mon_e, mon16_e;
    int   n_chk = 0, n_fail = 0, done_cnt = 0;
    int   atan_ref [16] = '{720, 425, 224, 114, 57, 28, 14, 7, 3, 1, 0, 0, 0, 0, 0, 0};

    function automatic void chk(string nm, longint act, longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endfunction

    function automatic void chk_tol(string nm, longint act, longint req, longint tol);
        n_chk++;
        if (act > req + tol || act < req - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", nm, act, req, tol);
        end
    endfunction

    // Textbook CORDIC from the rule set: d chosen from sign of z or y, atan from the listed table.
    function automatic void cordic_ref(input int iters, input bit mode, input int xi, input int yi,
                                       input int zi, output int xo, output int yo, output int zo);
        int x, y, z, xs, ys;
        x = xi;
        y = yi;
        z = mode ? 0 : zi;
        for (int k = 0; k < iters; k++) begin
            xs = x >>> k;
            ys = y >>> k;
            if (mode ? (y < 0) : (z >= 0)) begin
                x = x - ys; y = y + xs; z = z - atan_ref[k];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_ref[k];
            end
        end
        xo = x; yo = y; zo = z;
    endfunction

    function automatic exp_t make_exp(string name, int iters, bit mode, int x, int y, int z,
                                      bit approx, bit zchk, int ax, int ay, int az, int txy, int tz);
        exp_t e;
        e.name = name;
        cordic_ref(iters, mode, x, y, z, e.x, e.y, e.z);
        e.cyc = 0;
        e.approx = approx; e.zchk = zchk;
        e.ax = ax; e.ay = ay; e.az = az; e.txy = txy; e.tz = tz;
        return e;
    endfunction

    function automatic void check_result(string tag, exp_t e, logic [DW+1:0] ox, logic [DW+1:0] oy,
                                         logic [AW-1:0] oz, logic busy);
        int rx, ry, rz;
        rx = int'($signed(ox));
        ry = int'($signed(oy));
        rz = int'($signed(oz));
        chk({tag, " ", e.name, " x"}, rx, e.x);
        chk({tag, " ", e.name, " y"}, ry, e.y);
        chk({tag, " ", e.name, " z"}, rz, e.z);
        chk({tag, " ", e.name, " done_cycle"}, cyc, e.cyc);
        chk({tag, " ", e.name, " busy_at_done"}, longint'(busy), 0);
        if (e.approx) begin
            chk_tol({tag, " ", e.name, " x_approx"}, rx, e.ax, e.txy);
            chk_tol({tag, " ", e.name, " y_approx"}, ry, e.ay, e.txy);
            if (e.zchk) chk_tol({tag, " ", e.name, " z_approx"}, rz, e.az, e.tz);
        end
    endfunction

    always @(negedge c_clk) begin
        if (o_done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut unexpected_done: o_done=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = q.pop_front();
                check_result("dut", mon_e, o_x, o_y, o_z, o_busy);
            end
        end
    end

    always @(negedge c_clk) begin
        if (s_done === 1'b1) begin
            if (q16.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut16 unexpected_done: o_done=1 at cycle %0d, required 0", cyc);
            end else begin
                mon16_e = q16.pop_front();
                check_result("dut16", mon16_e, s_ox, s_oy, s_oz, s_busy);
            end
        end
    end

    // Called at a negedge with dut idle; returns at the negedge of the done cycle.
    task automatic issue(input exp_t e_in, input bit mode, input int x, input int y, input int z);
        exp_t e;
        e = e_in;
        i_start = 1'b1; i_mode = mode;
        i_x = 16'(x); i_y = 16'(y); i_z = 12'(z);
        e.cyc = cyc + 1 + ITER;
        q.push_back(e);
        @(negedge c_clk);
        chk({e.name, " busy_after_start"}, longint'(o_busy), 1);
        for (int k = 0; k < ITER; k++) begin
            i_start = 1'($urandom_range(1));
            i_mode  = 1'($urandom_range(1));
            i_x = 16'($urandom); i_y = 16'($urandom); i_z = 12'($urandom);
            @(negedge c_clk);
        end
        i_start = 1'b0;
    endtask

    task automatic issue16(input exp_t e_in, input bit mode, input int x, input int y, input int z);
        exp_t e;
        e = e_in;
        s_start = 1'b1; s_mode = mode;
        s_x = 16'(x); s_y = 16'(y); s_z = 12'(z);
        e.cyc = cyc + 1 + ITER16;
        q16.push_back(e);
        @(negedge c_clk);
        s_start = 1'b0;
        repeat (ITER16) @(negedge c_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        exp_t   e;
        longint base;
        int     d0;

        // reset held together with start: start must be dropped
        c_rst = 1'b1;
        i_start = 1'b1; i_mode = 1'b0; i_x = 16'd1000; i_y = '0; i_z = 12'd720;
        s_start = 1'b1; s_mode = 1'b0; s_x = 16'd1000; s_y = '0; s_z = '0;
        repeat (3) @(negedge c_clk);
        chk("reset o_busy", longint'(o_busy), 0);
        chk("reset o_done", longint'(o_done), 0);
        chk("reset o_x", longint'(o_x), 0);
        chk("reset o_y", longint'(o_y), 0);
        chk("reset o_z", longint'(o_z), 0);
        chk("reset dut16 o_busy", longint'(s_busy), 0);
        c_rst = 1'b0; i_start = 1'b0; s_start = 1'b0;
        @(negedge c_clk);
        chk("idle after reset", longint'(o_busy), 0);

        // directed vectors, issued back-to-back
        e = make_exp("rot45", ITER, 0, 1000, 0, 720, 1, 1, 1164, 1164, 0, 4, 2);
        issue(e, 0, 1000, 0, 720);
        e = make_exp("rot_m90", ITER, 0, 1000, 0, -1440, 1, 0, 0, -1647, 0, 4, 0);
        issue(e, 0, 1000, 0, -1440);
        e = make_exp("vec45", ITER, 1, 1000, 1000, 0, 1, 1, 2329, 0, 720, 4, 2);
        issue(e, 1, 1000, 1000, 0);

        // randomized legal operations, random gaps (0 = back-to-back)
        for (int n = 0; n < 40; n++) begin
            bit m;
            int x, y, z;
            m = 1'($urandom_range(1));
            y = int'($urandom_range(40000)) - 20000;
            if (m) begin
                x = int'($urandom_range(20000, 1));
                z = int'($urandom_range(4095)) - 2048;
            end else begin
                x = int'($urandom_range(40000)) - 20000;
                z = int'($urandom_range(2880)) - 1440;
            end
            e = make_exp($sformatf("rand%0d", n), ITER, m, x, y, z, 0, 0, 0, 0, 0, 0, 0);
            issue(e, m, x, y, z);
            repeat ($urandom_range(2)) @(negedge c_clk);
        end

        // i_start held for 30 cycles: accepts at t0, t0+13, t0+26
        e = make_exp("hold", ITER, 0, 800, -300, -500, 0, 0, 0, 0, 0, 0, 0);
        i_start = 1'b1; i_mode = 1'b0; i_x = 16'd800; i_y = 16'(-300); i_z = 12'(-500);
        base = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.cyc = base + ITER + k * (ITER + 1);
            q.push_back(e);
        end
        d0 = done_cnt;
        repeat (30) @(negedge c_clk);
        i_start = 1'b0;
        chk("hold done_pulses_in_30", done_cnt - d0, 2);
        for (int k = 0; k < 40 && q.size() > 0; k++) @(negedge c_clk);
        chk("hold drained", q.size(), 0);
        @(negedge c_clk);

        // reset at edge t0+5 aborts the operation with no done pulse
        i_start = 1'b1; i_mode = 1'b0; i_x = 16'd1000; i_y = 16'd500; i_z = 12'd300;
        @(negedge c_clk);
        i_start = 1'b0;
        repeat (4) @(negedge c_clk);
        c_rst = 1'b1;
        @(negedge c_clk);
        chk("midrst o_busy", longint'(o_busy), 0);
        chk("midrst o_done", longint'(o_done), 0);
        chk("midrst o_x", longint'(o_x), 0);
        chk("midrst o_y", longint'(o_y), 0);
        chk("midrst o_z", longint'(o_z), 0);
        c_rst = 1'b0;
        repeat (20) @(negedge c_clk);
        e = make_exp("after_rst", ITER, 0, 1000, 0, 720, 1, 1, 1164, 1164, 0, 4, 2);
        issue(e, 0, 1000, 0, 720);

        // 16-iteration instance and table contents
        e = make_exp("iter16_z0", ITER16, 0, 1000, 0, 0, 1, 0, 1647, 0, 0, 2, 0);
        issue16(e, 0, 1000, 0, 0);
        for (int n = 0; n < 4; n++) begin
            int x, y, z;
            x = int'($urandom_range(20000, 1));
            y = int'($urandom_range(40000)) - 20000;
            z = int'($urandom_range(2880)) - 1440;
            e = make_exp($sformatf("r16_%0d", n), ITER16, 1'(n), x, y, z, 0, 0, 0, 0, 0, 0, 0);
            issue16(e, 1'(n), x, y, z);
        end
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("atan16[%0d]", k), longint'(dut16.atan_tab[k]), atan_ref[k]);
            chk($sformatf("atan12[%0d]", k), longint'(dut.atan_tab[k]), atan_ref[k]);
        end

        for (int k = 0; k < 200 && (q.size() > 0 || q16.size() > 0); k++) @(negedge c_clk);
        chk("scoreboard drained", q.size() + q16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
